// File: rtl/matmul_launcher_if.sv
// rtl/matmul_launcher_if.sv - command, response and start/done signals of the matmul launcher
interface matmul_launcher_if #(
  parameter int ID_W  = 4,
  parameter int CYC_W = 16
);
  logic             cmd_valid;
  logic [ID_W-1:0]  cmd_id;
  logic             cmd_ready;
  logic             start;
  logic             done;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [ID_W-1:0]  rsp_id;
  logic [CYC_W-1:0] rsp_cycles;
  logic [1:0]       rsp_err;

  // Launcher side: takes commands and done, produces start and responses
  modport slave (
    input  cmd_valid, cmd_id, done, rsp_ready,
    output cmd_ready, start, rsp_valid, rsp_id, rsp_cycles, rsp_err
  );

  // Environment side: issues commands, models the control path, consumes responses
  modport master (
    output cmd_valid, cmd_id, done, rsp_ready,
    input  cmd_ready, start, rsp_valid, rsp_id, rsp_cycles, rsp_err
  );
endinterface

// File: rtl/matmul_launcher.sv
// rtl/matmul_launcher.sv - single-job start/done launcher with latency measurement and timeout
module matmul_launcher #(
  parameter int K       = 2,
  parameter int ID_W    = 4,
  parameter int CYC_W   = 16,
  parameter int TIMEOUT = 64,
  parameter int JCNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  matmul_launcher_if.slave  bus,
  output logic              busy,
  output logic [JCNT_W-1:0] jobs_done
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_RELEASE = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  localparam logic [1:0]       ERR_OK      = 2'd0;
  localparam logic [1:0]       ERR_TIMEOUT = 2'd1;
  localparam logic [1:0]       ERR_EARLY   = 2'd2;
  localparam logic [CYC_W-1:0] NOM_C       = CYC_W'(K + 3);
  localparam logic [CYC_W-1:0] TO_C        = CYC_W'(TIMEOUT);
  localparam logic [CYC_W-1:0] CYC_MAX     = '1;
  localparam bit               TO_EN       = (TIMEOUT != 0);

  state_t            state_q, state_d;
  logic              start_q, start_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  logic [CYC_W-1:0]  rsp_cycles_q, rsp_cycles_d;
  logic [1:0]        rsp_err_q, rsp_err_d;
  logic [JCNT_W-1:0] jobs_q, jobs_d;

  // A done still high from a previous job (e.g. late pulse after an abort) blocks a new start
  assign bus.cmd_ready  = (state_q == S_IDLE) && !bus.done;
  assign bus.start      = start_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_cycles = rsp_cycles_q;
  assign bus.rsp_err    = rsp_err_q;
  assign busy           = (state_q != S_IDLE);
  assign jobs_done      = jobs_q;

  // Next-state and output-register logic for the job lifecycle
  always_comb begin
    state_d      = state_q;
    start_d      = start_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    cyc_d        = cyc_q;
    rsp_cycles_d = rsp_cycles_q;
    rsp_err_d    = rsp_err_q;
    jobs_d       = jobs_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid && bus.cmd_ready) begin
          rsp_id_d = bus.cmd_id;
          cyc_d    = '0;
          start_d  = 1'b1;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // done takes priority over a timeout reached in the same cycle
        if (bus.done) begin
          rsp_cycles_d = cyc_q;
          rsp_err_d    = (cyc_q < NOM_C) ? ERR_EARLY : ERR_OK;
          start_d      = 1'b0;
          state_d      = S_RELEASE;
        end else if (TO_EN && (cyc_q == TO_C)) begin
          rsp_cycles_d = cyc_q;
          rsp_err_d    = ERR_TIMEOUT;
          start_d      = 1'b0;
          state_d      = S_RELEASE;
        end else if (cyc_q != CYC_MAX) begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      S_RELEASE: begin
        // Complete the level handshake before reporting
        if (!bus.done) begin
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          jobs_d      = jobs_q + JCNT_W'(1);
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      start_q      <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      cyc_q        <= '0;
      rsp_cycles_q <= '0;
      rsp_err_q    <= ERR_OK;
      jobs_q       <= '0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      cyc_q        <= cyc_d;
      rsp_cycles_q <= rsp_cycles_d;
      rsp_err_q    <= rsp_err_d;
      jobs_q       <= jobs_d;
    end
  end

endmodule

// File: tb/tb_matmul_launcher.sv
// tb/tb_matmul_launcher.sv - self-checking bench for matmul_launcher
module tb_matmul_launcher;

  localparam int K      = 2;
  localparam int ID_W   = 4;
  localparam int CYC_W  = 16;
  localparam int TO     = 8;
  localparam int JCNT_W = 16;
  localparam int NOM    = K + 3;
  localparam int NLIT   = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              busy;
  logic [JCNT_W-1:0] jobs_done;

  matmul_launcher_if #(.ID_W(ID_W), .CYC_W(CYC_W)) mif ();

  matmul_launcher #(
    .K(K), .ID_W(ID_W), .CYC_W(CYC_W), .TIMEOUT(TO), .JCNT_W(JCNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(mif.slave), .busy(busy), .jobs_done(jobs_done)
  );

  always #5 clk = ~clk;

  // Control-path model modes: 0 compliant, 1 early done with long hold, 2 silent, 3 forced done
  int dmode = 0;
  int drv_sc = 0;
  int drv_hold = 0;
  int wait_fails = 0;
  bit end_req = 1'b0;

  // Hand-computed responses in test order: id, cycles, err, jobs_done after acceptance
  int lit_id   [NLIT] = '{3, 1, 2, 3, 5, 6, 7, 9};
  int lit_cyc  [NLIT] = '{5, 5, 5, 5, 8, 2, 5, 5};
  int lit_err  [NLIT] = '{0, 0, 0, 0, 1, 2, 0, 0};
  int lit_jobs [NLIT] = '{1, 2, 3, 4, 5, 6, 7, 1};

  // Reference model state (job-level view of the launcher)
  int m_stage = 0;   // 0 waiting for a job, 1 job running, 2 waiting for done low, 3 response held
  int m_cnt = 0;
  bit m_rst = 1'b0;
  bit e_start = 1'b0;
  bit e_rv = 1'b0;
  int e_id = 0;
  int e_cyc = 0;
  int e_err = 0;
  int e_jobs = 0;

  int checks = 0;
  int errors = 0;
  int lidx = 0;
  int ncyc = 0;

  // Control-path model driving done a little after each rising edge
  initial begin
    mif.done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (mif.start) drv_sc++;
      else drv_sc = 0;
      case (dmode)
        0: mif.done = mif.start && (drv_sc > NOM);
        1: begin
          if (mif.start) begin
            mif.done = (drv_sc >= 3);
            drv_hold = 4;
          end else if (mif.done && drv_hold > 0) begin
            drv_hold--;
          end else begin
            mif.done = 1'b0;
          end
        end
        3: mif.done = 1'b1;
        default: mif.done = 1'b0;
      endcase
    end
  end

  // Reference model: advances on each rising edge from the sampled inputs
  initial begin
    forever begin
      @(posedge clk);
      m_rst = !rst_n;
      if (!rst_n) begin
        m_stage = 0; m_cnt = 0; e_start = 0; e_rv = 0;
        e_id = 0; e_cyc = 0; e_err = 0; e_jobs = 0;
      end else if (m_stage == 0) begin
        if (mif.cmd_valid && !mif.done) begin
          e_id = int'(mif.cmd_id); m_cnt = 0; e_start = 1; m_stage = 1;
        end
      end else if (m_stage == 1) begin
        if (mif.done || m_cnt == TO) begin
          e_cyc = m_cnt;
          e_err = mif.done ? ((m_cnt < NOM) ? 2 : 0) : 1;
          e_start = 0; m_stage = 2;
        end else if (m_cnt < 65535) begin
          m_cnt++;
        end
      end else if (m_stage == 2) begin
        if (!mif.done) begin e_rv = 1; m_stage = 3; end
      end else begin
        if (mif.rsp_ready) begin
          e_rv = 0; e_jobs = (e_jobs + 1) % 65536; m_stage = 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Single compare process: sampled on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      ncyc++;
      if (end_req || ncyc > 5000) break;
      if (m_rst) begin
        chk("reset_start", mif.start, 0);
        chk("reset_rsp_valid", mif.rsp_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_jobs", jobs_done, 0);
        chk("reset_rsp_id", mif.rsp_id, 0);
        chk("reset_rsp_cycles", mif.rsp_cycles, 0);
        chk("reset_rsp_err", mif.rsp_err, 0);
      end
      chk("start", mif.start, e_start);
      chk("rsp_valid", mif.rsp_valid, e_rv);
      chk("busy", busy, (m_stage != 0));
      chk("cmd_ready", mif.cmd_ready, (m_stage == 0) && !mif.done);
      chk("jobs_done", jobs_done, e_jobs);
      if (e_rv) begin
        chk("rsp_id", mif.rsp_id, e_id);
        chk("rsp_cycles", mif.rsp_cycles, e_cyc);
        chk("rsp_err", mif.rsp_err, e_err);
        if (mif.rsp_ready && rst_n) begin
          if (lidx < NLIT) begin
            chk("lit_rsp_id", mif.rsp_id, lit_id[lidx]);
            chk("lit_rsp_cycles", mif.rsp_cycles, lit_cyc[lidx]);
            chk("lit_rsp_err", mif.rsp_err, lit_err[lidx]);
            chk("lit_jobs_done", jobs_done + 1, lit_jobs[lidx]);
          end
          lidx++;
        end
      end
    end
    chk("sequence_completed", end_req, 1);
    chk("bounded_waits", wait_fails, 0);
    chk("response_count", lidx, NLIT);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  task automatic send(input int id);
    bit took;
    int n = 0;
    mif.cmd_id = id[ID_W-1:0];
    mif.cmd_valid = 1'b1;
    do begin
      took = mif.cmd_ready;
      @(posedge clk);
      #2;
      n++;
    end while (!took && n < 60);
    if (!took) wait_fails++;
    mif.cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (!mif.rsp_valid && n < 60) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (!mif.rsp_valid) wait_fails++;
  endtask

  task automatic take_rsp();
    bit took;
    int n = 0;
    mif.rsp_ready = 1'b1;
    do begin
      took = mif.rsp_valid;
      @(posedge clk);
      #2;
      n++;
    end while (!took && n < 60);
    if (!took) wait_fails++;
    mif.rsp_ready = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 60) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (busy) wait_fails++;
  endtask

  // Directed stimulus
  initial begin
    rst_n = 1'b0;
    mif.cmd_valid = 1'b0;
    mif.cmd_id = '0;
    mif.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #2;

    send(3);
    take_rsp();

    mif.rsp_ready = 1'b1;
    send(1);
    send(2);
    send(3);
    wait_idle();
    mif.rsp_ready = 1'b0;

    dmode = 2;
    send(5);
    take_rsp();
    dmode = 3;
    @(posedge clk);
    #2 mif.cmd_valid = 1'b1;
    mif.cmd_id = 4'd4;
    @(posedge clk);
    #2 mif.cmd_valid = 1'b0;
    dmode = 2;
    repeat (3) @(posedge clk);
    #2;

    dmode = 1;
    send(6);
    take_rsp();

    dmode = 0;
    send(7);
    wait_rsp();
    repeat (10) @(posedge clk);
    #2;
    take_rsp();

    dmode = 2;
    send(8);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    dmode = 0;
    send(9);
    take_rsp();

    repeat (3) @(posedge clk);
    #2 end_req = 1'b1;
  end

endmodule
